uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one UART Tx core among NUM_REQ requesters (command, telemetry, echo, debug).
//   Grants the core round-robin, locks the grant for a whole packet (up to MAX_PKT bytes),
//   launches one byte per Tx core frame, enforces an inter-packet gap in bit times, and
//   runs a watchdog on the core's start handshake. It is the sequencer in front of TxCore.
// PARAMETERS
//   NUM_REQ   4     number of requesters (2..8)
//   MAX_PKT   16    max bytes per grant before forced release (1..255)
//   GAP_BITS  2     idle bit times (BitTick_i pulses) between packets (0..15; 0 = no gap)
//   TIMEOUT   64    clk cycles allowed from TxStart_o to TxBusy_i rising (2..1023)
// PORTS
//   clk        in   1          system clock
//   rst        in   1          reset; synchronous and active-high
//   Req_i      in   NUM_REQ    per-requester byte valid; held until matching Ack_o
//   Data_i     in   8*NUM_REQ  byte of requester k at [8k+7:8k]
//   Last_i     in   NUM_REQ    byte presented is the last of its packet
//   Ack_o      out  NUM_REQ    one-cycle pulse: byte of requester k taken
//   Grant_o    out  NUM_REQ    one-hot current owner; 0 when no owner
//   TxData_o   out  8          byte to Tx core, stable from TxStart_o until next load
//   TxStart_o  out  1          one-cycle start pulse to Tx core
//   TxBusy_i   in   1          Tx core busy (high from start bit through stop bit)
//   BitTick_i  in   1          one-cycle pulse per bit time from baudrate generator
//   Err_o      out  1          one-cycle pulse: watchdog expired
//   Busy_o     out  1          high whenever state != IDLE
// BEHAVIOUR
//   Reset: state IDLE, Grant_o/Ack_o/TxStart_o/Err_o = 0, TxData_o = 8'h00, rr pointer = 0,
//     all counters 0. Reset mid-operation aborts any byte/packet; it applies on the next edge.
//   All outputs registered. States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
//   IDLE: if |Req_i, winner = first k with Req_i[k]=1 searching ptr, ptr+1, ... mod NUM_REQ;
//     Grant_o <= onehot(k), byte count <= 0, -> LOAD. Else stay.
//   LOAD (owner g): if Req_i[g]: TxData_o <= Data_i[g], last_r <= Last_i[g], TxStart_o and
//     Ack_o[g] pulse together next cycle, count+1, watchdog cleared, -> WAIT_BUSY.
//     If Req_i[g]=0: release (Grant_o <= 0, ptr <= g+1 mod NUM_REQ), -> IDLE; no error.
//   WAIT_BUSY: TxBusy_i=1 -> WAIT_DONE. Else watchdog+1; when it reaches TIMEOUT:
//     Err_o pulse, release, -> IDLE (no gap).
//   WAIT_DONE: on TxBusy_i=0: if last_r or count==MAX_PKT: release, -> GAP; else -> LOAD.
//   GAP: count BitTick_i pulses; after GAP_BITS pulses -> IDLE. GAP_BITS=0: GAP lasts 1 cycle.
//   Latency: Req_i in IDLE to TxStart_o = 2 cycles; WAIT_DONE exit to next TxStart_o = 2 cycles.
//   Requester may change Data_i/Last_i the cycle after its Ack_o; Req_i edges of non-owners
//     are ignored until IDLE. Ack_o is never asserted for a non-owner.
//   Simultaneous TxBusy_i=1 and watchdog expiry in WAIT_BUSY: busy wins, no Err_o.
//   ptr wraps NUM_REQ-1 -> 0. Byte count width 8 bits; watchdog width clog2(TIMEOUT+1).
//   Bytes with Last_i=0 after MAX_PKT reached continue as a new packet after re-arbitration.
// TESTING
//   1 Req_i[0] with 0x55,0xAA,0x0F (Last on 0x0F), core busy 10 cyc -> 3 TxStart_o, same order,
//     Grant_o=0001 throughout, 0000 after third frame, ptr=1.
//   2 After reset Req_i=1111, single-byte packets, GAP_BITS=2 -> grant order 0,1,2,3,0; no
//     TxStart_o earlier than 2 BitTick_i pulses after prior release.
//   3 Req 2 sends 4-byte packet, Req 1 raised after byte 1 -> no Ack_o[1] until 2's Last byte done.
//   4 MAX_PKT=4, Req 3 streams 6 bytes no Last, Req 0 waiting -> release after 4th byte, 0 next.
//   5 TxBusy_i held 0 -> Err_o pulse exactly TIMEOUT cycles after WAIT_BUSY entry, Grant_o=0.
//   6 rst=1 during WAIT_DONE -> next edge all outputs at reset values; new Req_i[1] granted first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester/Tx-core side signals of the UART Tx arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] data;
  logic [NUM_REQ-1:0]   last;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 bit_tick;
  logic                 err;
  logic                 busy;

  modport master (
    output req, data, last, tx_busy, bit_tick,
    input  ack, grant, tx_data, tx_start, err, busy
  );

  modport slave (
    input  req, data, last, tx_busy, bit_tick,
    output ack, grant, tx_data, tx_start, err, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART Tx core among NUM_REQ requesters,
// with per-packet grant lock, inter-packet gap and a start-handshake watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_PKT  = 16,
  parameter int unsigned GAP_BITS = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned GAP_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_ack;
  logic [7:0]         r_tx_data;
  logic               r_tx_start;
  logic               r_err;
  logic               r_busy;
  logic               r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [WD_W-1:0]    r_wd;
  logic [GAP_W-1:0]   r_gap;

  state_t             w_state_nxt;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [PTR_W-1:0]   w_owner_nxt;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [NUM_REQ-1:0] w_ack_nxt;
  logic [7:0]         w_tx_data_nxt;
  logic               w_start_nxt;
  logic               w_err_nxt;
  logic               w_last_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WD_W-1:0]    w_wd_nxt;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic [GAP_W-1:0]   w_gap_inc;
  logic               w_release;

  logic               w_found;
  logic [PTR_W-1:0]   w_winner;
  logic [PTR_W-1:0]   w_cand;
  logic [NUM_REQ-1:0] w_win_oh;
  logic               w_sel_req;
  logic               w_sel_last;
  logic [7:0]         w_sel_data;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // First requester at or after the round-robin pointer
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_cand = wrap_add(r_ptr, i);
      if (!w_found && bus.req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_win_oh = NUM_REQ'(1) << w_winner;

  // Current owner's request lane
  always_comb begin
    w_sel_req  = 1'b0;
    w_sel_last = 1'b0;
    w_sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (r_owner == PTR_W'(k)) begin
        w_sel_req  = bus.req[k];
        w_sel_last = bus.last[k];
        w_sel_data = bus.data[8*k +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_grant_nxt   = r_grant;
    w_ack_nxt     = '0;
    w_tx_data_nxt = r_tx_data;
    w_start_nxt   = 1'b0;
    w_err_nxt     = 1'b0;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_wd_nxt      = r_wd;
    w_gap_nxt     = r_gap;
    w_gap_inc     = r_gap + GAP_W'(1);
    w_release     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_win_oh;
          w_owner_nxt = w_winner;
          w_cnt_nxt   = '0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_sel_req) begin
          w_tx_data_nxt = w_sel_data;
          w_last_nxt    = w_sel_last;
          w_start_nxt   = 1'b1;
          w_ack_nxt     = r_grant;
          w_cnt_nxt     = r_cnt + CNT_W'(1);
          w_wd_nxt      = '0;
          w_state_nxt   = S_WAIT_BUSY;
        end else begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_BUSY: begin
        // Busy seen in the expiry cycle still counts as a successful start
        if (bus.tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else begin
          w_wd_nxt = r_wd + WD_W'(1);
          if (w_wd_nxt == WD_W'(TIMEOUT)) begin
            w_err_nxt   = 1'b1;
            w_release   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (r_last || (r_cnt == CNT_W'(MAX_PKT))) begin
            w_release   = 1'b1;
            w_gap_nxt   = '0;
            w_state_nxt = S_GAP;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_GAP: begin
        if (GAP_BITS == 0) begin
          w_state_nxt = S_IDLE;
        end else if (bus.bit_tick) begin
          if (w_gap_inc == GAP_W'(GAP_BITS)) w_state_nxt = S_IDLE;
          else                               w_gap_nxt   = w_gap_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_release) begin
      w_grant_nxt = '0;
      w_ptr_nxt   = wrap_add(r_owner, 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
      r_wd       <= '0;
      r_gap      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_grant    <= w_grant_nxt;
      r_ack      <= w_ack_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_start <= w_start_nxt;
      r_err      <= w_err_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_last     <= w_last_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wd       <= w_wd_nxt;
      r_gap      <= w_gap_nxt;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.ack      = r_ack;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_start = r_tx_start;
  assign bus.err      = r_err;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a Tx core model and
// a scoreboard of expected (requester, byte) launches in order.
module tb_uart_tx_arbiter;
  localparam int unsigned NR       = 4;
  localparam int unsigned MAXP     = 4;
  localparam int unsigned GAPB     = 2;
  localparam int unsigned TMO      = 16;
  localparam int          CORE_LEN = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int   vectors     = 0;
  int   miscompares = 0;
  logic core_en     = 1'b1;
  logic gap_chk     = 1'b0;
  logic err_ok      = 1'b0;

  logic [8:0]  rq [NR][$];
  logic [10:0] exp_q [$];

  int          bcnt       = 0;
  int          ticks      = 0;
  int          tdiv       = 0;
  logic        prev_busy  = 1'b0;
  logic [NR-1:0] prev_grant = '0;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ (NR),
    .MAX_PKT (MAXP),
    .GAP_BITS(GAPB),
    .TIMEOUT (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Requesters hold each byte until acked, then present the next queued one
  always @(negedge clk) begin : req_model
    logic [8*NR-1:0] d;
    logic [NR-1:0]   r;
    logic [NR-1:0]   l;
    d = '0;
    r = '0;
    l = '0;
    for (int k = 0; k < NR; k++) begin
      if (bus.ack[k] === 1'b1 && rq[k].size() != 0) void'(rq[k].pop_front());
      if (rq[k].size() != 0) begin
        r[k]          = 1'b1;
        l[k]          = rq[k][0][8];
        d[8*k +: 8]   = rq[k][0][7:0];
      end
    end
    bus.req  = r;
    bus.last = l;
    bus.data = d;
  end

  // Tx core: busy for CORE_LEN cycles after each start unless disabled
  always @(negedge clk) begin : core_model
    if (bus.tx_start === 1'b1 && core_en) bcnt = CORE_LEN;
    bus.tx_busy = (bcnt > 0);
    if (bcnt > 0) bcnt--;
  end

  // Scoreboard, gap tick counting and bit tick generation
  always @(negedge clk) begin : monitor
    logic [10:0]   e;
    logic [NR-1:0] exp_ack;
    exp_ack = '0;
    if (prev_grant != '0 && bus.grant == '0) ticks = 0;
    else if (bus.bit_tick === 1'b1)           ticks++;
    if (gap_chk && prev_busy && bus.busy === 1'b0)
      chk("gap_ticks", 32'(ticks), 32'(GAPB));
    if (bus.tx_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_start", 32'(bus.tx_start), 32'd0);
      end else begin
        e       = exp_q.pop_front();
        exp_ack = NR'(1) << e[10:8];
        chk("tx_data", 32'(bus.tx_data), 32'(e[7:0]));
        chk("grant_at_start", 32'(bus.grant), 32'(exp_ack));
      end
    end
    if (bus.tx_start === 1'b1 || bus.ack !== '0)
      chk("ack", 32'(bus.ack), 32'(exp_ack));
    if (bus.err === 1'b1 && !err_ok)
      chk("spurious_err", 32'(bus.err), 32'd0);
    prev_busy  = (bus.busy === 1'b1);
    prev_grant = bus.grant;
    tdiv++;
    bus.bit_tick = (tdiv % 3 == 0);
  end

  task automatic chk_reset();
    chk("rst_grant",    32'(bus.grant),    32'd0);
    chk("rst_ack",      32'(bus.ack),      32'd0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_err",      32'(bus.err),      32'd0);
    chk("rst_tx_data",  32'(bus.tx_data),  32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
  endtask

  task automatic wait_idle(input int max_cyc);
    int quiet = 0;
    for (int i = 0; i < max_cyc && quiet < 2; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) quiet++;
      else                   quiet = 0;
    end
    if (quiet < 2) chk("idle_timeout", 32'(bus.busy), 32'd0);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_start(input int max_cyc);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (bus.tx_start !== 1'b1 && i < max_cyc);
    if (bus.tx_start !== 1'b1) chk("start_timeout", 32'(bus.tx_start), 32'd1);
  endtask

  task automatic wait_ack(input int k, input int max_cyc);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (bus.ack[k] !== 1'b1 && i < max_cyc);
    if (bus.ack[k] !== 1'b1) chk("ack_timeout", 32'(bus.ack[k]), 32'd1);
  endtask

  task automatic push(input int k, input logic last, input logic [7:0] b, input logic expect_it);
    rq[k].push_back({last, b});
    if (expect_it) exp_q.push_back({3'(k), b});
  endtask

  initial begin : stim
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset();
    rst = 1'b0;

    // Three-byte packet from requester 0, latency and release
    @(posedge clk);
    push(0, 1'b0, 8'h55, 1'b1);
    push(0, 1'b0, 8'hAA, 1'b1);
    push(0, 1'b1, 8'h0F, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t1_grant_load", 32'(bus.grant), 32'h1);
    chk("t1_start_early", 32'(bus.tx_start), 32'd0);
    @(negedge clk);
    chk("t1_start_latency", 32'(bus.tx_start), 32'd1);
    wait_idle(300);
    chk("t1_grant_released", 32'(bus.grant), 32'd0);

    // Pointer moved to 1: requester 1 beats 0
    @(posedge clk);
    push(0, 1'b1, 8'h01, 1'b0);
    push(1, 1'b1, 8'h02, 1'b1);
    exp_q.push_back({3'd0, 8'h01});
    wait_idle(300);

    // Round robin over all four with gap enforcement
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst     = 1'b0;
    gap_chk = 1'b1;
    @(posedge clk);
    push(0, 1'b1, 8'hA0, 1'b0);
    push(0, 1'b1, 8'hA1, 1'b0);
    push(1, 1'b1, 8'hB1, 1'b0);
    push(2, 1'b1, 8'hC2, 1'b0);
    push(3, 1'b1, 8'hD3, 1'b0);
    exp_q.push_back({3'd0, 8'hA0});
    exp_q.push_back({3'd1, 8'hB1});
    exp_q.push_back({3'd2, 8'hC2});
    exp_q.push_back({3'd3, 8'hD3});
    exp_q.push_back({3'd0, 8'hA1});
    wait_idle(600);
    gap_chk = 1'b0;

    // Grant lock: requester 1 waits for 2's whole packet
    @(posedge clk);
    push(2, 1'b0, 8'h20, 1'b1);
    push(2, 1'b0, 8'h21, 1'b1);
    push(2, 1'b0, 8'h22, 1'b1);
    push(2, 1'b1, 8'h23, 1'b1);
    wait_ack(2, 50);
    @(posedge clk);
    push(1, 1'b1, 8'h1F, 1'b1);
    wait_idle(400);

    // MAX_PKT forced release, 0 served, then 3 resumes
    @(posedge clk);
    for (int b = 0; b < 6; b++) push(3, 1'b0, 8'(8'h30 + b), (b < 4));
    wait_ack(3, 50);
    @(posedge clk);
    push(0, 1'b1, 8'h0A, 1'b1);
    exp_q.push_back({3'd3, 8'h34});
    exp_q.push_back({3'd3, 8'h35});
    wait_idle(500);

    // Watchdog: core never goes busy
    @(posedge clk);
    core_en = 1'b0;
    err_ok  = 1'b1;
    push(1, 1'b1, 8'h77, 1'b1);
    wait_start(50);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.err !== 1'b1 && n < 40);
    chk("t5_err_latency", 32'(n), 32'(TMO));
    chk("t5_err_grant", 32'(bus.grant), 32'd0);
    chk("t5_err_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("t5_err_pulse", 32'(bus.err), 32'd0);
    err_ok  = 1'b0;
    core_en = 1'b1;
    wait_idle(100);

    // Reset while waiting for the core to finish
    @(posedge clk);
    push(2, 1'b0, 8'h66, 1'b1);
    push(2, 1'b1, 8'h67, 1'b0);
    wait_start(50);
    repeat (3) @(negedge clk);
    chk("t6_in_wait_done", 32'(bus.busy), 32'd1);
    @(posedge clk);
    rq[2].delete();
    push(1, 1'b1, 8'h11, 1'b1);
    push(3, 1'b1, 8'h3E, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_first_grant", 32'(bus.grant), 32'h2);
    wait_idle(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
